// File: rtl/comb_sweep_ctrl.sv
// Exhaustive input sweep sequencer with 16-bit MISR compaction of the sampled outputs.
// Optional golden-signature compare when GOLDEN_CMP_EN is defined.
module comb_sweep_ctrl #(
   parameter int          N_IN     = 6,
   parameter int          N_OUT    = 6,
   parameter int          SETTLE   = 1,
   parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [N_OUT-1:0] f,
`ifdef GOLDEN_CMP_EN
   input  logic [15:0]      golden_sig,
   output logic             pass,
   output logic             fail,
`endif
   output logic [N_IN-1:0]  x,
   output logic             busy,
   output logic             done,
   output logic             sig_valid,
   output logic [15:0]      signature
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [N_IN-1:0] X_ONE    = N_IN'(1);

   typedef enum logic [1:0] {IDLE, SWEEP_SETTLE, CAPT, FIN} state_t;

   state_t          state, state_n;
   logic [N_IN-1:0] x_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [15:0]     sig_n, misr_next, f_ext;
   logic            vld_n;
`ifdef GOLDEN_CMP_EN
   logic            pass_n, fail_n;
`endif

   assign f_ext     = 16'(f);
   assign misr_next = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ f_ext;
   assign busy      = (state == SWEEP_SETTLE) || (state == CAPT);
   assign done      = (state == FIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         x         <= '0;
         cnt       <= '0;
         signature <= '0;
         sig_valid <= 1'b0;
`ifdef GOLDEN_CMP_EN
         pass      <= 1'b0;
         fail      <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         x         <= x_n;
         cnt       <= cnt_n;
         signature <= sig_n;
         sig_valid <= vld_n;
`ifdef GOLDEN_CMP_EN
         pass      <= pass_n;
         fail      <= fail_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      x_n     = x;
      cnt_n   = cnt;
      sig_n   = signature;
      vld_n   = sig_valid;
`ifdef GOLDEN_CMP_EN
      pass_n  = pass;
      fail_n  = fail;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_n = SWEEP_SETTLE;
               x_n     = '0;
               sig_n   = SIG_SEED;
               vld_n   = 1'b0;
               cnt_n   = CNT_INIT;
`ifdef GOLDEN_CMP_EN
               pass_n  = 1'b0;
               fail_n  = 1'b0;
`endif
            end
         end
         SWEEP_SETTLE: begin
            if (abort) begin
               state_n = IDLE;
               x_n     = '0;
`ifdef GOLDEN_CMP_EN
               pass_n  = 1'b0;
               fail_n  = 1'b0;
`endif
            end else if (cnt == '0) begin
               state_n = CAPT;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         CAPT: begin
            // abort wins over the capture: the partial signature is left as-is
            if (abort) begin
               state_n = IDLE;
               x_n     = '0;
`ifdef GOLDEN_CMP_EN
               pass_n  = 1'b0;
               fail_n  = 1'b0;
`endif
            end else begin
               sig_n = misr_next;
               if (x == '1) begin
                  state_n = FIN;
               end else begin
                  x_n     = x + X_ONE;
                  cnt_n   = CNT_INIT;
                  state_n = SWEEP_SETTLE;
               end
            end
         end
         FIN: begin
            state_n = IDLE;
            vld_n   = 1'b1;
`ifdef GOLDEN_CMP_EN
            pass_n  = (signature == golden_sig);
            fail_n  = (signature != golden_sig);
`endif
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Directed bench for comb_sweep_ctrl: full sweep, small-width signature cases, abort and mid-run reset.
module tb_comb_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic start1, start2, abort1;
   logic zero1 = 1'b0;
   logic [5:0] f1 = '0;
   logic [1:0] f2 = '0;
   logic [5:0] x1;
   logic [1:0] x2, x3;
   logic busy1, done1, vld1, busy2, done2, vld2, busy3, done3, vld3;
   logic [15:0] sig1, sig2, sig3;
   logic [15:0] golden;
   logic pass1, fail1, pass2, fail2, pass3, fail3;
   logic [15:0] exp_sig;
   logic [15:0] tab3 [4];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   comb_sweep_ctrl dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f(f1),
`ifdef GOLDEN_CMP_EN
      .golden_sig(golden), .pass(pass1), .fail(fail1),
`endif
      .x(x1), .busy(busy1), .done(done1), .sig_valid(vld1), .signature(sig1));

   comb_sweep_ctrl #(.N_IN(2), .N_OUT(2), .SIG_SEED(16'h0001)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(zero1), .f(f2),
`ifdef GOLDEN_CMP_EN
      .golden_sig(golden), .pass(pass2), .fail(fail2),
`endif
      .x(x2), .busy(busy2), .done(done2), .sig_valid(vld2), .signature(sig2));

   comb_sweep_ctrl #(.N_IN(2), .N_OUT(2), .SIG_SEED(16'h0000)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(zero1), .f(x3),
`ifdef GOLDEN_CMP_EN
      .golden_sig(golden), .pass(pass3), .fail(fail3),
`endif
      .x(x3), .busy(busy3), .done(done3), .sig_valid(vld3), .signature(sig3));

`ifndef GOLDEN_CMP_EN
   assign {pass1, fail1, pass2, fail2, pass3, fail3} = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] misr_zero_run(input logic [15:0] seed, input int nvec);
      logic [15:0] s;
      s = seed;
      for (int i = 0; i < nvec; i++)
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000);
      return s;
   endfunction

   initial begin
      int n;
      tab3[0] = 16'h0000; tab3[1] = 16'h0001; tab3[2] = 16'h0000; tab3[3] = 16'h0003;
      rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; abort1 = 1'b0;
      exp_sig = misr_zero_run(16'hFFFF, 64);
      golden  = exp_sig;
      #8;
      chk("rst_x", 32'(x1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_vld", 32'(vld1), 32'd0);
      chk("rst_sig", 32'(sig1), 32'd0);
      chk("rst_sig2", 32'(sig2), 32'd0);
      #4 rst_n = 1'b1;
      tick();

      // full sweeps: default instance plus two 2-input instances
      start1 = 1'b1; start2 = 1'b1;
      tick();
      start1 = 1'b0; start2 = 1'b0;
      chk("s1_busy0", 32'(busy1), 32'd1);
      chk("s1_x0", 32'(x1), 32'd0);
      chk("s1_sigseed", 32'(sig1), 32'hFFFF);
      for (int k = 1; k <= 129; k++) begin
         tick();
         if (k < 128) begin
            chk("s1_x", 32'(x1), 32'(k / 2));
            chk("s1_busy", 32'(busy1), 32'd1);
            chk("s1_done_lo", 32'(done1), 32'd0);
         end
         if (k == 128) begin
            chk("s1_done", 32'(done1), 32'd1);
            chk("s1_busy_fin", 32'(busy1), 32'd0);
            chk("s1_vld_fin", 32'(vld1), 32'd0);
         end
         if (k == 129) begin
            chk("s1_done_end", 32'(done1), 32'd0);
            chk("s1_vld", 32'(vld1), 32'd1);
            chk("s1_sig", 32'(sig1), 32'(exp_sig));
`ifdef GOLDEN_CMP_EN
            chk("s1_pass", 32'(pass1), 32'd1);
            chk("s1_fail", 32'(fail1), 32'd0);
`endif
         end
         if (k == 2 || k == 4 || k == 6 || k == 8)
            chk("s3_vec_sig", 32'(sig3), 32'(tab3[k/2-1]));
         if (k == 8) chk("s2_done", 32'(done2), 32'd1);
         if (k == 9) begin
            chk("s2_sig", 32'(sig2), 32'h0010);
            chk("s2_vld", 32'(vld2), 32'd1);
            chk("s3_sig", 32'(sig3), 32'h0003);
            chk("s3_vld", 32'(vld3), 32'd1);
         end
      end

      // abort at x=17, with a start request during busy that must be dropped
      golden = exp_sig ^ 16'h0001;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
`ifdef GOLDEN_CMP_EN
      chk("ab_pass_clr", 32'(pass1), 32'd0);
`endif
      chk("ab_vld_clr", 32'(vld1), 32'd0);
      repeat (34) tick();
      chk("ab_x17", 32'(x1), 32'd17);
      abort1 = 1'b1; start1 = 1'b1;
      tick();
      abort1 = 1'b0; start1 = 1'b0;
      chk("ab_x", 32'(x1), 32'd0);
      chk("ab_busy", 32'(busy1), 32'd0);
      chk("ab_done", 32'(done1), 32'd0);
      chk("ab_vld", 32'(vld1), 32'd0);
      tick();
      chk("ab_noqueue", 32'(busy1), 32'd0);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int k = 1; k <= 129; k++) begin
         tick();
         if (k == 128) chk("ab2_done", 32'(done1), 32'd1);
         if (k == 129) begin
            chk("ab2_sig", 32'(sig1), 32'(exp_sig));
            chk("ab2_vld", 32'(vld1), 32'd1);
`ifdef GOLDEN_CMP_EN
            chk("ab2_pass", 32'(pass1), 32'd0);
            chk("ab2_fail", 32'(fail1), 32'd1);
`endif
         end
      end

      // asynchronous reset in the middle of a run
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (80) tick();
      chk("rr_x40", 32'(x1), 32'd40);
      #1 rst_n = 1'b0;
      #1;
      chk("rr_x", 32'(x1), 32'd0);
      chk("rr_busy", 32'(busy1), 32'd0);
      chk("rr_done", 32'(done1), 32'd0);
      chk("rr_vld", 32'(vld1), 32'd0);
      chk("rr_sig", 32'(sig1), 32'd0);
      chk("rr_pf", 32'({pass1, fail1}), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 200) begin
         tick();
         n++;
      end
      chk("rr_len", 32'(n), 32'd128);
      tick();
      chk("rr_vld_end", 32'(vld1), 32'd1);
      chk("rr_sig_end", 32'(sig1), 32'(exp_sig));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
